// File: rtl/systolic_tile.sv
// systolic_tile: output-stationary ROWS x COLS multiply-accumulate array with internal input skew.
// Build option: define SYSTOLIC_SIGNED_EN for two's-complement operands (unsigned otherwise).
module systolic_tile #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [K_W-1:0]                       k_len,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ROWS-1:0][DATA_W-1:0]          a_in,
  input  logic [COLS-1:0][DATA_W-1:0]          b_in,
  output logic                                 busy,
  output logic                                 done,
  output logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] out
);

  localparam int PW = 2 * DATA_W;
  localparam int FL = ROWS + COLS - 2;
  localparam int DL = ROWS + COLS - 1;
  localparam int FW = 6;
  localparam logic [FW-1:0] FL_LAST = FW'((FL > 0) ? FL - 1 : 0);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [K_W-1:0] k_len_q;
  logic [K_W-1:0] beat_cnt;
  logic [FW-1:0]  flush_cnt;
  logic           start_acc;
  logic           vld_p0;
  logic           last_beat;

  logic [DATA_W-1:0] a_tap [ROWS][DL+1];
  logic [DATA_W-1:0] b_tap [COLS][DL+1];
  logic [DATA_W-1:0] a_dly_p1 [ROWS][DL];
  logic [DATA_W-1:0] b_dly_p1 [COLS][DL];

  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
`ifdef SYSTOLIC_SIGNED_EN
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    logic signed [PW-1:0] p;
    logic [ACC_W-1:0]     r;
    ax = {{DATA_W{a[DATA_W-1]}}, a};
    bx = {{DATA_W{b[DATA_W-1]}}, b};
    p  = ax * bx;
    r  = {ACC_W{p[PW-1]}};
    r[PW-1:0] = p;
    return r;
`else
    logic [PW-1:0]    ax;
    logic [PW-1:0]    bx;
    logic [PW-1:0]    p;
    logic [ACC_W-1:0] r;
    ax = {{DATA_W{1'b0}}, a};
    bx = {{DATA_W{1'b0}}, b};
    p  = ax * bx;
    r  = '0;
    r[PW-1:0] = p;
    return r;
`endif
  endfunction

  assign start_acc = start && ((state == IDLE) || (state == DONE));
  assign in_ready  = reset && (state == STREAM);
  assign busy      = reset && ((state == STREAM) || (state == FLUSH));
  assign done      = reset && (state == DONE);
  assign vld_p0    = in_valid && in_ready;
  assign last_beat = vld_p0 && ((beat_cnt + K_W'(1)) == k_len_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (k_len == '0) ? DONE : STREAM;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      STREAM: if (last_beat) state_next = (FL == 0) ? DONE : FLUSH;
      FLUSH:  if (flush_cnt == FL_LAST) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (start_acc) begin
        k_len_q   <= k_len;
        beat_cnt  <= '0;
        flush_cnt <= '0;
      end else begin
        if (vld_p0) beat_cnt <= beat_cnt + K_W'(1);
        if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
      end
    end
  end

  // stage p0: tap d of a channel is that channel delayed d cycles; bubbles enter as zero
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_tap[i][0] = vld_p0 ? a_in[i] : '0;
      for (int d = 1; d <= DL; d++) a_tap[i][d] = a_dly_p1[i][d-1];
    end
    for (int j = 0; j < COLS; j++) begin
      b_tap[j][0] = vld_p0 ? b_in[j] : '0;
      for (int d = 1; d <= DL; d++) b_tap[j][d] = b_dly_p1[j][d-1];
    end
  end

  // stage p1: row i skew plus j right-hops (and column j skew plus i down-hops) meet at PE(i,j) after i+j cycles
  always_ff @(posedge clk) begin
    if (!reset || start_acc) begin
      for (int i = 0; i < ROWS; i++)
        for (int d = 0; d < DL; d++) a_dly_p1[i][d] <= '0;
      for (int j = 0; j < COLS; j++)
        for (int d = 0; d < DL; d++) b_dly_p1[j][d] <= '0;
      out <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++)
        for (int d = 0; d < DL; d++) a_dly_p1[i][d] <= a_tap[i][d];
      for (int j = 0; j < COLS; j++)
        for (int d = 0; d < DL; d++) b_dly_p1[j][d] <= b_tap[j][d];
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          out[i][j] <= out[i][j] + mul_ext(a_tap[i][i+j], b_tap[j][i+j]);
    end
  end

endmodule

// File: tb/tb_systolic_tile.sv
// tb_systolic_tile: directed and randomized jobs on a 4x4 and a 2x2 tile, checked against a matrix-product model.
`timescale 1ns/1ps
module tb_systolic_tile;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int KW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic                     s4, v4, r4, busy4, done4;
  logic [KW-1:0]            k4;
  logic [3:0][DW-1:0]       a4, b4;
  logic [3:0][3:0][AW-1:0]  out4;

  logic                     s2, v2, r2, busy2, done2;
  logic [KW-1:0]            k2;
  logic [1:0][DW-1:0]       a2, b2;
  logic [1:0][1:0][AW-1:0]  out2;

  systolic_tile #(.ROWS(4), .COLS(4), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut4 (
    .clk(clk), .reset(rst_n), .start(s4), .k_len(k4), .in_valid(v4), .in_ready(r4),
    .a_in(a4), .b_in(b4), .busy(busy4), .done(done4), .out(out4));

  systolic_tile #(.ROWS(2), .COLS(2), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut2 (
    .clk(clk), .reset(rst_n), .start(s2), .k_len(k2), .in_valid(v2), .in_ready(r2),
    .a_in(a2), .b_in(b2), .busy(busy2), .done(done2), .out(out2));

  int checks = 0;
  int failures = 0;
  int pat [6] = '{1, 0, 1, 1, 0, 1};

  logic [DW-1:0] ma [4][16];
  logic [DW-1:0] mb [16][4];
  logic [AW-1:0] exp_out [4][4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int klen);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        logic [AW-1:0] acc;
        acc = '0;
        for (int k = 0; k < klen; k++) begin
          longint p;
`ifdef SYSTOLIC_SIGNED_EN
          p = longint'($signed(ma[i][k])) * longint'($signed(mb[k][j]));
`else
          p = longint'(ma[i][k]) * longint'(mb[k][j]);
`endif
          acc = acc + AW'(p);
        end
        exp_out[i][j] = acc;
      end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 16; k++)
      for (int x = 0; x < 4; x++) begin
        ma[x][k] = DW'($urandom);
        mb[k][x] = DW'($urandom);
      end
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int k = 0; k < 16; k++)
      for (int x = 0; x < 4; x++) begin
        ma[x][k] = av;
        mb[k][x] = bv;
      end
  endtask

  task automatic check_out4(input string name);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s out[%0d][%0d]", name, i, j), out4[i][j], exp_out[i][j]);
  endtask

  // Called right after a negedge; returns at the negedge where done is expected (or after an abort).
  task automatic job4(input string name, input int klen, input int vmode,
                      input bit flush_start, input bit abort);
    int beats;
    int step;
    int v;
    model(klen);
    s4 = 1'b1;
    k4 = KW'(klen);
    v4 = 1'($urandom_range(0, 1));
    a4 = $urandom;
    b4 = $urandom;
    @(negedge clk);
    s4 = 1'b0;
    if (klen == 0) begin
      check({name, " done"}, done4, 1);
      check({name, " busy"}, busy4, 0);
      check_out4(name);
      return;
    end
    check({name, " busy after start"}, busy4, 1);
    beats = 0;
    step = 0;
    while (beats < klen && step < 200) begin
      check({name, " in_ready stream"}, r4, 1);
      check({name, " no early done"}, done4, 0);
      case (vmode)
        0:       v = 1;
        1:       v = pat[step % 6];
        default: v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      endcase
      v4 = 1'(v);
      if (v != 0) begin
        for (int i = 0; i < 4; i++) a4[i] = ma[i][beats];
        for (int j = 0; j < 4; j++) b4[j] = mb[beats][j];
      end else begin
        a4 = $urandom;
        b4 = $urandom;
      end
      @(negedge clk);
      if (v != 0) beats++;
      step++;
    end
    check({name, " beats accepted"}, beats, klen);
    v4 = 1'b1;
    a4 = $urandom;
    b4 = $urandom;
    for (int n = 1; n < 7; n++) begin
      check({name, " flush done"}, done4, 0);
      check({name, " flush in_ready"}, r4, 0);
      check({name, " flush busy"}, busy4, 1);
      if (flush_start && n == 1) begin
        s4 = 1'b1;
        k4 = 8'd3;
      end else begin
        s4 = 1'b0;
      end
      if (abort && n == 2) begin
        rst_n = 1'b0;
        for (int w = 0; w < 2; w++) begin
          @(negedge clk);
          check({name, " rst busy"}, busy4, 0);
          check({name, " rst done"}, done4, 0);
          check({name, " rst in_ready"}, r4, 0);
        end
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            check($sformatf("%s rst out[%0d][%0d]", name, i, j), out4[i][j], 0);
        rst_n = 1'b1;
        v4 = 1'b0;
        for (int w = 0; w < 10; w++) begin
          @(negedge clk);
          check({name, " no done after abort"}, done4, 0);
        end
        return;
      end
      @(negedge clk);
    end
    v4 = 1'b0;
    s4 = 1'b0;
    check({name, " done"}, done4, 1);
    check({name, " done busy"}, busy4, 0);
    check({name, " done in_ready"}, r4, 0);
    check_out4(name);
  endtask

  task automatic idle4(input string name);
    @(negedge clk);
    check({name, " done single pulse"}, done4, 0);
    check({name, " idle busy"}, busy4, 0);
    @(negedge clk);
    check({name, " out hold"}, out4[3][3], exp_out[3][3]);
    check({name, " out hold 00"}, out4[0][0], exp_out[0][0]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s4 = 0; k4 = '0; v4 = 0; a4 = '0; b4 = '0;
    s2 = 0; k2 = '0; v2 = 0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("reset busy4", busy4, 0);
    check("reset done4", done4, 0);
    check("reset in_ready4", r4, 0);
    check("reset out4[3][3]", out4[3][3], 0);
    check("reset busy2", busy2, 0);
    check("reset out2[1][1]", out2[1][1], 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy4", busy4, 0);

    // 2x2 identity times [[1,2],[3,4]]
    s2 = 1'b1; k2 = 8'd2;
    @(negedge clk);
    s2 = 1'b0;
    check("id busy", busy2, 1);
    check("id in_ready k0", r2, 1);
    v2 = 1'b1; a2 = {8'd0, 8'd1}; b2 = {8'd2, 8'd1};
    @(negedge clk);
    check("id in_ready k1", r2, 1);
    a2 = {8'd1, 8'd0}; b2 = {8'd4, 8'd3};
    @(negedge clk);
    v2 = 1'b0;
    check("id done n1", done2, 0);
    check("id in_ready flush", r2, 0);
    @(negedge clk);
    check("id done n2", done2, 0);
    @(negedge clk);
    check("id done n3", done2, 1);
    check("id out00", out2[0][0], 1);
    check("id out01", out2[0][1], 2);
    check("id out10", out2[1][0], 3);
    check("id out11", out2[1][1], 4);
    @(negedge clk);
    check("id done pulse", done2, 0);

    // 4x4 with bubbles, constant operands
    fill_const(8'd2, 8'd3);
    job4("bubble", 4, 1, 1'b0, 1'b0);
    check("bubble out00 const", out4[0][0], 32'd24);
    check("bubble out33 const", out4[3][3], 32'd24);
    idle4("bubble");

    // k_len = 0 clears previous result
    job4("klen0", 0, 0, 1'b0, 1'b0);
    idle4("klen0");

    // start pulsed during FLUSH must be ignored
    fill_rand();
    job4("flushstart", 6, 2, 1'b1, 1'b0);
    idle4("flushstart");

    // back-to-back: second start lands in the DONE cycle
    fill_rand();
    job4("b2b first", 5, 0, 1'b0, 1'b0);
    fill_rand();
    job4("b2b second", 7, 2, 1'b0, 1'b0);
    fill_rand();
    job4("b2b third", 3, 1, 1'b0, 1'b0);
    idle4("b2b");

    // reset during FLUSH aborts, then a normal job
    fill_rand();
    job4("abort", 5, 0, 1'b0, 1'b1);
    fill_rand();
    job4("after abort", 4, 2, 1'b0, 1'b0);
    idle4("after abort");

    // signedness
    fill_const(8'hFF, 8'h02);
    job4("sign", 1, 0, 1'b0, 1'b0);
`ifdef SYSTOLIC_SIGNED_EN
    check("sign const", out4[2][1], 32'hFFFF_FFFE);
`else
    check("sign const", out4[2][1], 32'd510);
`endif
    idle4("sign");

    // randomized jobs
    for (int r = 0; r < 6; r++) begin
      fill_rand();
      job4($sformatf("rand%0d", r), int'($urandom_range(1, 12)), 2, 1'b0, 1'b0);
      if (r % 2 == 0) idle4($sformatf("rand%0d", r));
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_tile.md
SYSTOLIC_TILE -- requirements
Module: systolic_tile

Interface
REQ-001 The block SHALL have the following parameters:
- ROWS, default 4, number of array rows (A channels), legal 1..16.
- COLS, default 4, number of array columns (B channels), legal 1..16.
- DATA_W, default 8, operand width.
- ACC_W, default 32, accumulator width, legal ACC_W >= 2*DATA_W.
- K_W, default 8, width of k_len.

REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low; the single clock and the synchronous active-low reset are already decided.
- start  in  1  begin a new product; sampled only in IDLE or DONE.
- k_len  in  K_W  inner dimension (beat count); sampled with start.
- in_valid  in  1  a_in/b_in carry one beat.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- a_in  in  DATA_W x ROWS  A column k, element i for row i.
- b_in  in  DATA_W x COLS  B row k, element j for column j.
- busy  out  1  FSM in STREAM or FLUSH.
- done  out  1  one-cycle pulse; out is complete.
- out  out  ACC_W x ROWS x COLS  out[i][j] = sum over k of a[i][k]*b[k][j].

Function
REQ-003 The FSM SHALL have four states, IDLE, STREAM, FLUSH and DONE, with these transitions:
- IDLE/DONE to STREAM on start with k_len>0.
- IDLE/DONE to DONE on start with k_len=0.
- STREAM to FLUSH on the cycle the k_len-th beat is accepted, or to DONE directly when ROWS+COLS-2=0.
- FLUSH to DONE after exactly ROWS+COLS-2 FLUSH cycles.
- DONE to IDLE after one cycle unless start is asserted.
REQ-004 in_ready SHALL be 1 only in STREAM; beats offered in other states SHALL be ignored.
REQ-005 The block SHALL skew its inputs internally: row i of A is delayed i cycles and column j of B is delayed j cycles, then both propagate through the output-stationary PE grid (A moving right, B moving down, one register per PE).
REQ-006 A cycle in STREAM with in_valid=0 SHALL inject a zero bubble on all channels; alignment is preserved and there is no stall.
REQ-007 A beat accepted in cycle t SHALL be reflected in out[i][j] from cycle t+i+j+1.
REQ-008 done SHALL pulse exactly in cycle t_L+ROWS+COLS-1, where t_L is the last accept cycle.
REQ-009 Every out[i][j] SHALL be final when done is 1 and SHALL hold until the next start is accepted.
REQ-010 Multiply SHALL be DATA_W x DATA_W to 2*DATA_W, extended to ACC_W; accumulation SHALL wrap modulo 2^ACC_W.
REQ-011 An accepted start SHALL clear all accumulators and skew/pipeline registers in the following cycle, together with the transition.
REQ-012 start SHALL be ignored in STREAM and FLUSH.
REQ-013 k_len=0 SHALL yield all-zero out and a done pulse in the cycle after start.
REQ-014 start asserted in the DONE cycle SHALL be accepted; back-to-back jobs SHALL therefore have no idle cycle.

Reset
REQ-015 With reset=0 at a clock edge, the FSM SHALL go to IDLE and out, the skew registers and the beat counter SHALL go to 0; busy, done and in_ready SHALL be 0 while reset is held.
REQ-016 Reset asserted mid-job (STREAM or FLUSH) SHALL abort the job without any done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-017 When SYSTOLIC_SIGNED_EN is defined, operands SHALL be two's-complement and products sign-extended to ACC_W.
REQ-018 When SYSTOLIC_SIGNED_EN is undefined, operands SHALL be unsigned and products zero-extended; all other behaviour SHALL be identical.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- 2x2 identity: ROWS=COLS=2, k_len=2, A=I, B=[[1,2],[3,4]] with valid every cycle -> out=[[1,2],[3,4]]; done exactly 3 cycles after the last accept.
- 4x4 with bubbles: k_len=4, all a=2, b=3, in_valid pattern 1,0,1,1,0,1 -> every out=24; in_ready=1 only in STREAM; done 7 cycles after the last accept.
- k_len=0 and ignored start: start with k_len=0 -> done next cycle with out all 0; start pulsed during FLUSH -> no effect, job completes unchanged.
- Back-to-back: start in the DONE cycle with new operands -> accumulators cleared, second result correct, no idle cycle between jobs.
- Reset mid-job: reset=0 during FLUSH -> out=0, no done; next job correct.
- Signedness: a=8'hFF, b=8'h02, k_len=1 -> out=-2 (32'hFFFFFFFE) with SYSTOLIC_SIGNED_EN, 510 without it.
